// File: rtl/add64_seq_ctrl.sv
// Sequencer for a 64-bit ripple adder: gathers eight 16-bit beats into A/B,
// waits for the adder to settle, then hands the captured sum downstream.
module add64_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_cin,
  output logic [63:0] A_out,
  output logic [63:0] B_out,
  output logic        Cin_out,
  input  logic [63:0] Sum_in,
  input  logic        Cout_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_sum,
  output logic        res_cout,
  output logic [15:0] op_count
);

  localparam int unsigned BEAT_W   = 3;
  localparam int unsigned SETTLE_W = 8;
  // A zero settle time would never let the counter hit 1; clamp it to one cycle.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_EFF);
  localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(7);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                accept;
  logic                settle_end;
  logic                consume;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    accept     = 1'b0;
    settle_end = 1'b0;
    consume    = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (beat == LAST_BEAT)) state_next = SETTLE;
      end
      SETTLE: begin
        settle_end = (settle_cnt <= SETTLE_W'(1));
        if (settle_end) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        consume   = res_ready;
        if (res_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Operand assembly, settle timing, result capture and op counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat       <= '0;
      settle_cnt <= '0;
      A_out      <= '0;
      B_out      <= '0;
      Cin_out    <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        beat <= beat + BEAT_W'(1);
        if (beat == '0) Cin_out <= in_cin;
        // Little-endian halfwords: beats 0..3 fill A, 4..7 fill B.
        if (!beat[2]) A_out[{beat[1:0], 4'b0000} +: 16] <= in_data;
        else          B_out[{beat[1:0], 4'b0000} +: 16] <= in_data;
        if (beat == LAST_BEAT) settle_cnt <= SETTLE_INIT;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt - SETTLE_W'(1);
        if (settle_end) begin
          res_sum  <= Sum_in;
          res_cout <= Cout_in;
        end
      end
      if (consume) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// Self-checking bench for add64_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized operations against a behavioural model.
module tb_add64_seq_ctrl;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_cin;
  logic [63:0] A_out, B_out;
  logic        Cin_out;
  logic [63:0] Sum_in;
  logic        Cout_in;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_sum;
  logic        res_cout;
  logic [15:0] op_count;

  int vectors    = 0;
  int miscompares = 0;
  logic [15:0] exp_cnt = '0;

  add64_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cin(in_cin),
    .A_out(A_out), .B_out(B_out), .Cin_out(Cin_out),
    .Sum_in(Sum_in), .Cout_in(Cout_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .op_count(op_count)
  );

  // The external ripple adder the block drives
  assign {Cout_in, Sum_in} = {1'b0, A_out} + {1'b0, B_out} + 65'(Cin_out);

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive beats 0..nbeats-1 of an operation; caller sits at posedge+1.
  task automatic send_beats(input logic [63:0] a, input logic [63:0] b, input logic cin,
                            input bit gapped, input int nbeats);
    logic [127:0] ops;
    ops = {b, a};
    for (int k = 0; k < nbeats; k++) begin
      int waits = 0;
      while (!in_ready && waits < 50) begin
        @(posedge clk); #1; waits++;
      end
      if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = ops[16*k +: 16];
      in_cin   = (k == 0) ? cin : ~cin;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'hDEAD;
      if (gapped) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input bit gapped, input logic [63:0] exp_sum, input logic exp_cout);
    int edges = 0;
    send_beats(a, b, cin, gapped, 8);
    // Beat 7 edge is one edge behind when gapped; undo that for latency.
    if (gapped) edges = 1;
    while (!res_valid && edges < 300) begin
      @(posedge clk); #1; edges++;
    end
    check("latency", 64'(edges), 64'(SETTLE));
    check("res_valid", 64'(res_valid), 64'd1);
    check("res_sum", res_sum, exp_sum);
    check("res_cout", 64'(res_cout), 64'(exp_cout));
    check("A_out", A_out, a);
    check("B_out", B_out, b);
    check("Cin_out", 64'(Cin_out), 64'(cin));
    check("in_ready_done", 64'(in_ready), 64'd0);
  endtask

  task automatic consume(input logic [63:0] exp_sum);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    check("res_valid_after", 64'(res_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("op_count", 64'(op_count), 64'(exp_cnt));
    check("res_sum_retain", res_sum, exp_sum);
  endtask

  // Reference: plain 65-bit arithmetic of the operands
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + 65'(cin);
  endfunction

  initial begin
    vec_t vecs[5];
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] r;

    vecs[0] = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b0, 64'h8, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 64'h2222_2222_2222_2212, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; res_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_A", A_out, 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // res_ready while loading must be ignored
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("ready_ignored_cnt", 64'(op_count), 64'(exp_cnt));
    check("ready_ignored_rdy", 64'(in_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, (i % 2) == 1, vecs[i].exp_sum, vecs[i].exp_cout);
      consume(vecs[i].exp_sum);
    end

    // Back-pressure: result must hold for ten stalled cycles
    run_op(64'hAAAA_5555_0000_FFFF, 64'h1111_2222_3333_4444, 1'b0, 1'b0,
           64'hBBBB_7777_3334_4443, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_sum", res_sum, 64'hBBBB_7777_3334_4443);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    consume(64'hBBBB_7777_3334_4443);

    // Asynchronous reset in the middle of loading
    send_beats(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_A", A_out, 64'd0);
    check("mid_rst_B", B_out, 64'd0);
    check("mid_rst_cin", 64'(Cin_out), 64'd0);
    check("mid_rst_sum", res_sum, 64'd0);
    check("mid_rst_cout", 64'(res_cout), 64'd0);
    check("mid_rst_cnt", 64'(op_count), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    exp_cnt = '0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0,
           64'h0000_0000_0002_0000, 1'b0);
    consume(64'h0000_0000_0002_0000);

    // Randomized operations with random gaps and consume delays
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (i == 0) rb = ~ra;
      r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, $urandom_range(0, 1) == 1, r[63:0], r[64]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume(r[63:0]);
    end

    // op_count wrap from a preloaded 0xFFFF
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    exp_cnt = 16'hFFFF;
    @(posedge clk); #1;
    check("preload_cnt", 64'(op_count), 64'hFFFF);
    run_op(64'd7, 64'd9, 1'b0, 1'b0, 64'd16, 1'b0);
    consume(64'd16);
    check("wrap_cnt", 64'(op_count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
